// File: rtl/ehgu_fifo_sc.sv
// Single-clock FIFO with level, almost/full/empty flags, sticky error flags,
// synchronous flush, operation enable and selectable registered-read / FWFT output.
module ehgu_fifo_sc #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned FWFT     = 0,
   localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk0,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   input  logic             err_clr,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din,
   input  logic             dout_ready,
   output logic             dout_valid,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    level,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic full_c, empty_c;
   logic push_ok_c, push_rej_c, pop_ok_c, pop_empty_c;
   logic [WIDTH-1:0] rd_data_c;

   assign full_c    = (level_q == CW'(DEPTH));
   assign empty_c   = (level_q == '0);
   assign rd_data_c = mem_q[rptr_q];

   // Events qualified by enable; flush overrides every transfer and error event
   assign push_ok_c   = en & ~clr & din_valid & ~full_c;
   assign push_rej_c  = en & ~clr & din_valid & full_c;
   assign pop_ok_c    = en & ~clr & dout_ready & ~empty_c;
   assign pop_empty_c = (FWFT == 0) & en & ~clr & dout_ready & empty_c;

   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      level_d      = level_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      overflow_d   = overflow_q & ~err_clr;
      underflow_d  = underflow_q & ~err_clr;

      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (push_ok_c) begin
            wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
         end
         if (pop_ok_c) begin
            rptr_d       = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
            dout_d       = rd_data_c;
            dout_valid_d = 1'b1;
         end
         if (push_ok_c && !pop_ok_c) begin
            level_d = level_q + CW'(1);
         end else if (pop_ok_c && !push_ok_c) begin
            level_d = level_q - CW'(1);
         end
      end

      // A same-cycle error event beats err_clr
      if (push_rej_c) begin
         overflow_d = 1'b1;
      end
      if (pop_empty_c) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk0 or negedge rstn) begin
      if (!rstn) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         level_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         level_q      <= level_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage array is intentionally left unreset
   always_ff @(posedge clk0) begin
      if (push_ok_c) begin
         mem_q[wptr_q] <= din;
      end
   end

   assign level        = level_q;
   assign full         = full_c;
   assign empty        = empty_c;
   assign almost_full  = (level_q >= CW'(AF_LEVEL));
   assign almost_empty = (level_q <= CW'(AE_LEVEL));
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign dout_valid   = (FWFT != 0) ? ~empty_c  : dout_valid_q;
   assign dout         = (FWFT != 0) ? rd_data_c : dout_q;

endmodule

// File: tb/tb_ehgu_fifo_sc.sv
// Bench for ehgu_fifo_sc: a registered-read DEPTH=4 instance and an FWFT DEPTH=5
// instance share one stimulus stream and are checked against queue models.
module tb_ehgu_fifo_sc;

   logic clk = 1'b0;
   logic rstn;
   logic en, clr, err_clr, vin, rdy;
   logic [7:0] din;

   logic       dv0, dv1;
   logic [7:0] do0, do1;
   logic [2:0] lvl0, lvl1;
   logic       full0, full1, empty0, empty1, af0, af1, ae0, ae1;
   logic       ovf0, ovf1, udf0, udf1;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: queue contents plus registered-read output and sticky flags
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       m_dv0, m_dv1;
   logic [7:0] m_do0, m_do1;
   logic       m_ovf0, m_ovf1, m_udf0, m_udf1;

   always #5 clk = ~clk;

   ehgu_fifo_sc #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_rr (
      .clk0(clk), .rstn(rstn), .en(en), .clr(clr), .err_clr(err_clr),
      .din_valid(vin), .din(din), .dout_ready(rdy),
      .dout_valid(dv0), .dout(do0), .level(lvl0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(udf0)
   );

   ehgu_fifo_sc #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_ft (
      .clk0(clk), .rstn(rstn), .en(en), .clr(clr), .err_clr(err_clr),
      .din_valid(vin), .din(din), .dout_ready(rdy),
      .dout_valid(dv1), .dout(do1), .level(lvl1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(udf1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q0.delete(); q1.delete();
      m_dv0 = 1'b0; m_dv1 = 1'b0; m_do0 = '0; m_do1 = '0;
      m_ovf0 = 1'b0; m_ovf1 = 1'b0; m_udf0 = 1'b0; m_udf1 = 1'b0;
   endtask

   task automatic model_step(ref logic [7:0] q[$], input int dep, input bit fw,
                             ref logic dv, ref logic [7:0] dq, ref logic ovf, ref logic udf);
      bit push, pop, ovf_ev, udf_ev;
      logic [7:0] tmp;
      ovf_ev = 1'b0;
      udf_ev = 1'b0;
      if (clr) begin
         q.delete();
         dv = 1'b0;
      end else if (en) begin
         push   = vin && (q.size() < dep);
         pop    = rdy && (q.size() != 0);
         ovf_ev = vin && (q.size() == dep);
         udf_ev = !fw && rdy && (q.size() == 0);
         if (pop) begin
            tmp = q.pop_front();
            dq  = tmp;
         end
         dv = pop;
         if (push) q.push_back(din);
      end else begin
         dv = 1'b0;
      end
      if (err_clr) begin
         ovf = 1'b0;
         udf = 1'b0;
      end
      if (ovf_ev) ovf = 1'b1;
      if (udf_ev) udf = 1'b1;
   endtask

   task automatic check_all();
      chk("rr_level",  32'(lvl0),   32'(q0.size()));
      chk("rr_full",   32'(full0),  32'(q0.size() == 4));
      chk("rr_empty",  32'(empty0), 32'(q0.size() == 0));
      chk("rr_afull",  32'(af0),    32'(q0.size() >= 3));
      chk("rr_aempty", 32'(ae0),    32'(q0.size() <= 1));
      chk("rr_dvalid", 32'(dv0),    32'(m_dv0));
      chk("rr_dout",   32'(do0),    32'(m_do0));
      chk("rr_ovf",    32'(ovf0),   32'(m_ovf0));
      chk("rr_udf",    32'(udf0),   32'(m_udf0));
      chk("ft_level",  32'(lvl1),   32'(q1.size()));
      chk("ft_full",   32'(full1),  32'(q1.size() == 5));
      chk("ft_empty",  32'(empty1), 32'(q1.size() == 0));
      chk("ft_afull",  32'(af1),    32'(q1.size() >= 3));
      chk("ft_aempty", 32'(ae1),    32'(q1.size() <= 2));
      chk("ft_dvalid", 32'(dv1),    32'(q1.size() != 0));
      if (q1.size() != 0) chk("ft_dout", 32'(do1), 32'(q1[0]));
      chk("ft_ovf",    32'(ovf1),   32'(m_ovf1));
      chk("ft_udf",    32'(udf1),   32'(1'b0));
   endtask

   // One clock: model consumes the inputs seen at the edge, outputs checked 1 time unit later
   task automatic step();
      @(posedge clk);
      if (!rstn) begin
         model_reset();
      end else begin
         model_step(q0, 4, 1'b0, m_dv0, m_do0, m_ovf0, m_udf0);
         model_step(q1, 5, 1'b1, m_dv1, m_do1, m_ovf1, m_udf1);
      end
      #1;
      check_all();
   endtask

   task automatic drive(input logic e, input logic c, input logic ec,
                        input logic v, input logic [7:0] d, input logic r);
      en = e; clr = c; err_clr = ec; vin = v; din = d; rdy = r;
   endtask

   initial begin
      logic [7:0] exp_words[4];
      logic [7:0] got_q[$];
      int w;
      int budget;
      bit acc;

      exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33; exp_words[3] = 8'h44;
      rstn = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      model_reset();
      #1;
      check_all();
      step();
      rstn = 1'b1;

      // Fill the 4-deep FIFO, then drain it in order
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, exp_words[i], 1'b0);
         step();
      end
      chk("tp_full",  32'(full0), 32'd1);
      chk("tp_level", 32'(lvl0),  32'd4);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         step();
         chk("tp_pop_dv",   32'(dv0), 32'd1);
         chk("tp_pop_dout", 32'(do0), 32'(exp_words[i]));
      end
      chk("tp_empty", 32'(empty0), 32'd1);

      // Push into a full FIFO while popping: pop wins, push dropped
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, exp_words[i], 1'b0);
         step();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
      step();
      chk("ovf_dout",  32'(do0),  32'h11);
      chk("ovf_flag",  32'(ovf0), 32'd1);
      chk("ovf_level", 32'(lvl0), 32'd3);

      // Enable low: nothing moves
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
      step();
      chk("hold_level", 32'(lvl0), 32'd3);
      chk("hold_ovf",   32'(ovf0), 32'd1);

      // Flush keeps sticky flags
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
      step();
      chk("clr_level", 32'(lvl0),   32'd0);
      chk("clr_empty", 32'(empty0), 32'd1);
      chk("clr_ovf",   32'(ovf0),   32'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      step();
      chk("errclr_ovf", 32'(ovf0), 32'd0);

      // Pop request on empty; same-cycle err_clr loses to the event
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      step();
      chk("udf_dv",    32'(dv0),  32'd0);
      chk("udf_flag",  32'(udf0), 32'd1);
      chk("udf_level", 32'(lvl0), 32'd0);
      chk("udf_fwft",  32'(udf1), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      step();
      chk("udf_errclr_race", 32'(udf0), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      step();
      chk("udf_cleared", 32'(udf0), 32'd0);

      // Threshold sweep 0..4
      chk("sweep_ae_0", 32'(ae0), 32'd1);
      chk("sweep_af_0", 32'(af0), 32'd0);
      for (int l = 1; l <= 4; l++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(l), 1'b0);
         step();
         chk("sweep_ae", 32'(ae0), 32'(l <= 1));
         chk("sweep_af", 32'(af0), 32'(l >= 3));
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step();

      // FWFT stream of 12 words with random consumer stalls across pointer wrap
      w = 0;
      budget = 0;
      while (got_q.size() < 12 && budget < 300) begin
         drive(1'b1, 1'b0, 1'b0, w < 12, 8'(w), 1'($urandom_range(0, 1)));
         if (dv1 && rdy) got_q.push_back(do1);
         acc = vin && (q1.size() < 5);
         step();
         if (acc) w++;
         budget++;
      end
      chk("stream_count", 32'(got_q.size()), 32'd12);
      for (int i = 0; i < 12 && i < got_q.size(); i++) begin
         chk("stream_word", 32'(got_q[i]), 32'(i));
      end

      // Random traffic with an asynchronous reset in the middle
      for (int c = 0; c < 500; c++) begin
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0),
               8'($urandom), 1'($urandom_range(0, 1)));
         if (c == 250) begin
            #2;
            rstn = 1'b0;
            #1;
            model_reset();
            check_all();
            chk("arst_level", 32'(lvl0), 32'd0);
            step();
            rstn = 1'b1;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
